// File: rtl/bg_scroll_renderer_if.sv
// Scroll-update handshake between a scroll controller (master) and bg_scroll_renderer (slave).
interface bg_scroll_renderer_if;
    logic [9:0] scroll_x;
    logic [9:0] scroll_y;
    logic       scroll_valid;
    logic       scroll_ready;
    logic       frame_applied;

    modport master (
        output scroll_x,
        output scroll_y,
        output scroll_valid,
        input  scroll_ready,
        input  frame_applied
    );

    modport slave (
        input  scroll_x,
        input  scroll_y,
        input  scroll_valid,
        output scroll_ready,
        output frame_applied
    );
endinterface

// File: rtl/bg_scroll_renderer.sv
// Scrolling, wrap-around background renderer: screen coords -> ROM address -> palette -> registered RGB.
// Optional transparent-key output enabled by defining BG_TRANSPARENT_KEY_EN.
module bg_scroll_renderer #(
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned IMG_H       = 240,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned ADDR_W      = 17
`ifdef BG_TRANSPARENT_KEY_EN
    ,
    parameter int unsigned KEY_IDX     = 0
`endif
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    bg_scroll_renderer_if.slave scroll,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
`ifdef BG_TRANSPARENT_KEY_EN
    ,
    output logic              opaque
`endif
);

    logic [9:0]        act_x_q, act_x_d;
    logic [9:0]        act_y_q, act_y_d;
    logic [9:0]        pend_x_q, pend_x_d;
    logic [9:0]        pend_y_q, pend_y_d;
    logic              pending_q, pending_d;
    logic              frame_applied_q, frame_applied_d;
    logic [ADDR_W-1:0] rom_address_q, rom_address_d;
    logic              blank_p1_q, blank_p1_d;
    logic              blank_p2_q, blank_p2_d;
    logic [3:0]        red_q, red_d;
    logic [3:0]        green_q, green_d;
    logic [3:0]        blue_q, blue_d;
`ifdef BG_TRANSPARENT_KEY_EN
    logic              opaque_q, opaque_d;
`endif

    logic              frame_start;
    logic              xfer;
    logic [9:0]        req_x, req_y;
    logic [9:0]        dx_s, dy_s;
    logic [10:0]       ix_sum, iy_sum;
    logic [10:0]       ix, iy;

    // Scroll handshake: out-of-range offsets collapse to 0; updates only land at frame start.
    always_comb begin
        frame_start     = (DrawX == 10'd0) && (DrawY == 10'd0);
        xfer            = scroll.scroll_valid && !pending_q;
        req_x           = (32'(scroll.scroll_x) >= IMG_W) ? '0 : scroll.scroll_x;
        req_y           = (32'(scroll.scroll_y) >= IMG_H) ? '0 : scroll.scroll_y;

        act_x_d         = act_x_q;
        act_y_d         = act_y_q;
        pend_x_d        = pend_x_q;
        pend_y_d        = pend_y_q;
        pending_d       = pending_q;
        frame_applied_d = 1'b0;

        if (frame_start) begin
            if (pending_q) begin
                act_x_d         = pend_x_q;
                act_y_d         = pend_y_q;
                pending_d       = 1'b0;
                frame_applied_d = 1'b1;
            end else if (xfer) begin
                act_x_d         = req_x;
                act_y_d         = req_y;
                frame_applied_d = 1'b1;
            end
        end else if (xfer) begin
            pend_x_d  = req_x;
            pend_y_d  = req_y;
            pending_d = 1'b1;
        end
    end

    // Address stage: offsets are always < image size, so one conditional subtract wraps.
    always_comb begin
        dx_s          = DrawX >> SCALE_SHIFT;
        dy_s          = DrawY >> SCALE_SHIFT;
        ix_sum        = {1'b0, dx_s} + {1'b0, act_x_q};
        iy_sum        = {1'b0, dy_s} + {1'b0, act_y_q};
        ix            = (32'(ix_sum) >= IMG_W) ? (ix_sum - 11'(IMG_W)) : ix_sum;
        iy            = (32'(iy_sum) >= IMG_H) ? (iy_sum - 11'(IMG_H)) : iy_sum;
        rom_address_d = ADDR_W'(iy) * ADDR_W'(IMG_W) + ADDR_W'(ix);
    end

    // Colour stage: blank travels two flops to line up with rom_q, the ROM having one cycle of latency.
    always_comb begin
        blank_p1_d = blank;
        blank_p2_d = blank_p1_q;
`ifdef BG_TRANSPARENT_KEY_EN
        opaque_d   = (rom_q != IDX_W'(KEY_IDX));
        if (blank_p2_q && opaque_d) begin
`else
        if (blank_p2_q) begin
`endif
            red_d   = pal_red;
            green_d = pal_green;
            blue_d  = pal_blue;
        end else begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            act_x_q         <= '0;
            act_y_q         <= '0;
            pend_x_q        <= '0;
            pend_y_q        <= '0;
            pending_q       <= 1'b0;
            frame_applied_q <= 1'b0;
            rom_address_q   <= '0;
            blank_p1_q      <= 1'b0;
            blank_p2_q      <= 1'b0;
            red_q           <= '0;
            green_q         <= '0;
            blue_q          <= '0;
`ifdef BG_TRANSPARENT_KEY_EN
            opaque_q        <= 1'b0;
`endif
        end else begin
            act_x_q         <= act_x_d;
            act_y_q         <= act_y_d;
            pend_x_q        <= pend_x_d;
            pend_y_q        <= pend_y_d;
            pending_q       <= pending_d;
            frame_applied_q <= frame_applied_d;
            rom_address_q   <= rom_address_d;
            blank_p1_q      <= blank_p1_d;
            blank_p2_q      <= blank_p2_d;
            red_q           <= red_d;
            green_q         <= green_d;
            blue_q          <= blue_d;
`ifdef BG_TRANSPARENT_KEY_EN
            opaque_q        <= opaque_d;
`endif
        end
    end

    assign scroll.scroll_ready  = !pending_q;
    assign scroll.frame_applied = frame_applied_q;
    assign rom_address          = rom_address_q;
    assign pal_index            = rom_q;
    assign red                  = red_q;
    assign green                = green_q;
    assign blue                 = blue_q;
`ifdef BG_TRANSPARENT_KEY_EN
    assign opaque               = opaque_q;
`endif

endmodule

// File: doc/bg_scroll_renderer.md
BG_SCROLL_RENDERER -- requirements
Module: bg_scroll_renderer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 320, meaning background image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 240, meaning background image height in pixels.
REQ-003 The block SHALL have parameter SCALE_SHIFT, default 1, meaning screen-to-image downscale as a right shift (1 = 2x stretch).
REQ-004 The block SHALL have parameter IDX_W, default 4, meaning palette index width; parameter ADDR_W, default 17, meaning ROM address width.
REQ-005 The block SHALL have port vga_clk, input, 1 bit, meaning the single clock for all logic.
REQ-006 The block SHALL have port reset_n, input, 1 bit, meaning synchronous active-low reset.
REQ-007 The block SHALL have ports DrawX and DrawY, input, 10 bits each, meaning current screen pixel coordinates.
REQ-008 The block SHALL have port blank, input, 1 bit, meaning display enable (1 = visible pixel).
REQ-009 The block SHALL have ports scroll_x, input, 10 bits, and scroll_y, input, 10 bits, meaning the requested image offsets.
REQ-010 The block SHALL have ports scroll_valid, input, 1 bit, and scroll_ready, output, 1 bit, meaning the scroll update handshake.
REQ-011 The block SHALL have ports rom_address, output, ADDR_W bits, and rom_q, input, IDX_W bits, meaning the synchronous ROM fetch with 1-cycle read latency on vga_clk.
REQ-012 The block SHALL have ports pal_index, output, IDX_W bits, and pal_red, pal_green, pal_blue, input, 4 bits each, meaning the combinational palette lookup.
REQ-013 The block SHALL have ports red, green, blue, output, 4 bits each, meaning the registered pixel colour.
REQ-014 The block SHALL have port frame_applied, output, 1 bit, meaning a one-cycle pulse when a pending scroll takes effect.

Function
REQ-015 Frame start SHALL be the cycle where DrawX==0 and DrawY==0.
REQ-016 The image coordinates SHALL be ix = ((DrawX>>SCALE_SHIFT) + act_x) and iy = ((DrawY>>SCALE_SHIFT) + act_y), each reduced by one subtraction of IMG_W or IMG_H when greater than or equal to it, giving horizontal and vertical wrap-around.
REQ-017 rom_address SHALL be registered as iy*IMG_W + ix, truncated to ADDR_W, one cycle after DrawX/DrawY are sampled.
REQ-018 pal_index SHALL equal rom_q.
REQ-019 red/green/blue SHALL be registered from pal_red/green/blue when blank delayed by 2 cycles is 1, and SHALL otherwise be 0.
REQ-020 The total latency from a DrawX/DrawY/blank sample to the corresponding red/green/blue SHALL be exactly 3 cycles, with no bubbles.
REQ-021 scroll_ready SHALL be 1 when no update is pending; a transfer SHALL occur on scroll_valid && scroll_ready.
REQ-022 An accepted scroll_x >= IMG_W or scroll_y >= IMG_H SHALL be stored as 0 for that axis.
REQ-023 An accepted update SHALL be held pending and copied to act_x/act_y at the next frame start, with frame_applied pulsing for that cycle and scroll_ready returning to 1 on the following cycle.
REQ-024 A transfer in the frame-start cycle itself SHALL be applied immediately, taking effect from the next DrawX sample, and SHALL pulse frame_applied; no pending state SHALL be left.
REQ-025 While an update is pending, scroll_ready SHALL be 0 and scroll_valid SHALL be ignored.
REQ-026 act_x/act_y SHALL never change except at a frame start, so there is no tearing within a frame.

Reset
REQ-027 On a vga_clk edge with reset_n=0, act_x, act_y, the pending state, rom_address, red, green, blue and frame_applied SHALL become 0, and scroll_ready SHALL become 1.
REQ-028 Reset asserted mid-frame or with an update pending SHALL discard the pending update; pipeline contents SHALL be cleared, so outputs are 0 for the 3 cycles after release.

Configuration
REQ-029 With macro BG_TRANSPARENT_KEY_EN defined, a parameter KEY_IDX (default 0) SHALL exist; a fetched index equal to KEY_IDX SHALL output red/green/blue = 0 and an extra output port opaque (1 bit, registered, aligned with red) = 0, otherwise 1.
REQ-030 Without BG_TRANSPARENT_KEY_EN, neither KEY_IDX nor opaque SHALL exist, and every index SHALL be rendered through the palette.

Verification
REQ-031 Reset, scroll 0, DrawX=10, DrawY=6, blank=1 -> rom_address=3*320+5=965 after 1 cycle; red/green/blue equal to the palette entry after 3 cycles.
REQ-032 Mid-frame transfer of scroll_x=300 -> scroll_ready=0; at the next frame start frame_applied=1 and act_x=300; DrawX=100 -> ix=(50+300)-320=30.
REQ-033 scroll_y=239, DrawY=4 -> iy=(2+239)-240=1 (vertical wrap); scroll_y=240 accepted -> stored 0.
REQ-034 Transfer in the cycle with DrawX=0 and DrawY=0 -> applied in the same frame, frame_applied=1, scroll_ready stays 1.
REQ-035 blank=0 at sample N -> red/green/blue=0 at N+3 regardless of rom_q; reset_n=0 with an update pending -> pending lost, scroll_ready=1.
REQ-036 With BG_TRANSPARENT_KEY_EN and KEY_IDX=0, rom_q=0 -> opaque=0 and rgb=0; rom_q=5 -> opaque=1 and the palette colour is output.
